// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared constants, state encoding and offset type for wave_capture
package wave_pkg;

    localparam int FRAME_LEN  = 256;
    localparam int RAM_ADDR_W = 9;
    localparam int OFFSET_W   = 8;

    localparam logic [1:0] ST_ARMED  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    typedef logic [OFFSET_W-1:0] offset_t;

    function automatic logic is_last_offset(input offset_t off);
        return off == offset_t'(FRAME_LEN - 1);
    endfunction

endpackage

// File: rtl/wave_capture_trigger.sv
// rtl/wave_capture_trigger.sv - zero-crossing detector (negative to non-negative) on accepted samples
module wave_capture_trigger
    import wave_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic accept,
    input  logic sample_sign,
    output logic crossing
);

    // Only the sign of the previous sample matters for crossing detection.
    logic prev_sample_sign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_sample_sign <= 1'b0;
        end else if (accept) begin
            prev_sample_sign <= sample_sign;
        end
    end

    assign crossing = accept && prev_sample_sign && !sample_sign;

endmodule

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - triggered double-buffered waveform capture; optional WAVE_CAPTURE_DECIMATE_EN
module wave_capture
    import wave_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [SAMPLE_W-1:0]   new_sample_in,
    input  logic                  wave_display_idle,
    output logic [RAM_ADDR_W-1:0] write_address,
    output logic                  write_enable,
    output logic [7:0]            write_sample,
    output logic                  read_index
);

    logic [1:0] state;
    offset_t    count;
    logic       accept;
    logic       crossing;
    logic [7:0] display_sample;

`ifdef WAVE_CAPTURE_DECIMATE_EN
    // Toggles on every raw strobe; the first strobe after reset is accepted.
    logic decim_skip;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            decim_skip <= 1'b0;
        end else if (new_sample_ready) begin
            decim_skip <= ~decim_skip;
        end
    end

    assign accept = new_sample_ready && !decim_skip;
`else
    assign accept = new_sample_ready;
`endif

    assign display_sample = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};

    generate
        if (SAMPLE_W > 8) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^new_sample_in[SAMPLE_W-9:0];
        end
    endgenerate

    wave_capture_trigger u_trigger (
        .clk         (clk),
        .reset       (reset),
        .accept      (accept),
        .sample_sign (new_sample_in[SAMPLE_W-1]),
        .crossing    (crossing)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_ARMED;
            count         <= '0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                ST_ARMED: begin
                    if (crossing) begin
                        write_enable  <= 1'b1;
                        write_address <= {~read_index, offset_t'(0)};
                        write_sample  <= display_sample;
                        count         <= offset_t'(1);
                        state         <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (accept) begin
                        write_enable  <= 1'b1;
                        write_address <= {~read_index, count};
                        write_sample  <= display_sample;
                        // Offset wraps to 0 naturally after the last slot.
                        count         <= count + offset_t'(1);
                        if (is_last_offset(count)) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wave_display_idle) begin
                        read_index <= ~read_index;
                        state      <= ST_ARMED;
                    end
                end
                default: begin
                    state <= ST_ARMED;
                end
            endcase
        end
    end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, meaning audio sample width in bits (signed two's complement, minimum 8).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port new_sample_ready  input  1  one-cycle strobe; new_sample_in valid this cycle.
REQ-005 SHALL have port new_sample_in  input  SAMPLE_W  signed audio sample.
REQ-006 SHALL have port wave_display_idle  input  1  level; high while the display is outside the waveform region and may swap buffers.
REQ-007 SHALL have port write_address  output  9  sample RAM write address {buffer half, 8-bit offset}.
REQ-008 SHALL have port write_enable  output  1  sample RAM write strobe.
REQ-009 SHALL have port write_sample  output  8  unsigned display sample.
REQ-010 SHALL have port read_index  output  1  half the display reads; the capture writes the other half.

Function
REQ-011 SHALL implement a three-state FSM: ARMED, ACTIVE, WAIT.
REQ-012 SHALL keep prev_sample, updated with new_sample_in on every accepted strobe in all states; reset value 0.
REQ-013 SHALL detect trigger in ARMED on an accepted strobe when prev_sample MSB is 1 and new_sample_in MSB is 0 (negative to non-negative).
REQ-014 SHALL, on trigger, write the triggering sample at offset 0, set count to 1, and enter ACTIVE.
REQ-015 SHALL, in ACTIVE, write each accepted sample at offset count, then increment count.
REQ-016 SHALL, after offset 255 is written, enter WAIT; count wraps to 0; no write beyond offset 255.
REQ-017 SHALL, in WAIT, ignore samples for writing; when wave_display_idle is high, toggle read_index and enter ARMED in the same cycle.
REQ-018 SHALL form write_address as {~read_index, offset}, so writes never touch the half being displayed.
REQ-019 SHALL form write_sample as {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-8]} (top 8 bits, offset-binary).
REQ-020 SHALL register write_enable, write_address and write_sample: asserted exactly one cycle after the accepting strobe, for one cycle.
REQ-021 SHALL ignore wave_display_idle in ARMED and ACTIVE; a frame in progress always completes.
REQ-022 SHALL ignore new_sample_ready while in WAIT except for updating prev_sample.

Reset
REQ-023 SHALL on reset: state ARMED, count 0, prev_sample 0, read_index 0, write_enable 0, write_address 0, write_sample 0.
REQ-024 SHALL abandon any partial frame on reset mid-ACTIVE; no write strobe is issued in the cycle after reset deasserts unless a strobe is accepted then.

Configuration
REQ-025 SHALL, with WAVE_CAPTURE_DECIMATE_EN defined, accept only every second new_sample_ready (internal toggle, reset 0, first strobe after reset accepted) for trigger, capture and prev_sample; frame spans 512 input samples.
REQ-026 SHALL, without WAVE_CAPTURE_DECIMATE_EN, accept every new_sample_ready.

Structure
REQ-027 SHALL place state encoding, FRAME_LEN=256 and RAM_ADDR_W=9 in shared package wave_pkg.
REQ-028 SHALL implement zero-crossing detection (prev_sample register plus compare) in sub-module wave_capture_trigger.

Verification
REQ-029 SHALL verify reset: after reset, read_index=0, write_enable=0, state ARMED.
REQ-030 SHALL verify trigger: samples -100 then +50 -> write at address 0x100 with data 0x80; samples +10 then +20 in ARMED -> no write.
REQ-031 SHALL verify full frame: trigger then 255 more strobes -> 256 writes, addresses 0x100..0x1FF, then FSM enters WAIT; the next 10 strobes -> no write.
REQ-032 SHALL verify swap: in WAIT, wave_display_idle=1 -> read_index becomes 1 next cycle; next frame writes 0x000..0x0FF.
REQ-033 SHALL verify reset mid-frame: reset after 100 writes -> read_index=0, next trigger writes again from 0x100.
REQ-034 SHALL verify decimation (macro defined): 20 strobes in ACTIVE -> exactly 10 writes.
